multi_countdown: RTL and testbench

MULTI_COUNTDOWN -- requirements
Module: multi_countdown

---
 rtl/multi_countdown.sv | 143 ++++++++++++++
 tb/tb_multi_countdown.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_countdown.sv
`default_nettype none
// ============================================================================
//  Module   : multi_countdown
//  Purpose  : CH independent seconds countdown timers with a shared buzzer.
//             Optional auto-reload enabled by `define CDT_AUTORELOAD_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module multi_countdown #(
    parameter int CH       = 2,
    parameter int W        = 17,
    parameter int TICK_DIV = 100_000_000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [CH-1:0]   clear,
    input  logic [CH-1:0]   load,
    input  logic [CH*W-1:0] tar_sec,
    input  logic [CH-1:0]   run,
    input  logic [CH-1:0]   pause,
    input  logic [CH-1:0]   ack,
`ifdef CDT_AUTORELOAD_EN
    input  logic [CH-1:0]   auto_rl,
`endif
    output logic [CH*W-1:0] seconds,
    output logic [2*CH-1:0] state,
    output logic [CH-1:0]   expired,
    output logic            buzzer
);

    localparam int            SW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [SW-1:0] c_SUB_LAST = SW'(TICK_DIV - 1);

    localparam logic [1:0] c_ST_IDLE  = 2'b00;
    localparam logic [1:0] c_ST_PAUSE = 2'b01;
    localparam logic [1:0] c_ST_RUN   = 2'b10;
    localparam logic [1:0] c_ST_ALARM = 2'b11;

    logic [CH-1:0] w_alarm;
    logic          r_buzzer;

    for (genvar i = 0; i < CH; i++) begin : g_ch
        logic [1:0]    r_st,  w_st_nx;
        logic [W-1:0]  r_sec, w_sec_nx;
        logic [SW-1:0] r_sub, w_sub_nx;
        logic          r_exp, w_exp_nx;
        logic [W-1:0]  w_tar;

        assign w_tar = tar_sec[i*W +: W];

`ifdef CDT_AUTORELOAD_EN
        logic [W-1:0] r_reload;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_reload <= '0;
            end else if (load[i] && !clear[i]) begin
                r_reload <= w_tar;
            end
        end
`endif

        // Priority: clear > load > ack > second tick > run/pause.
        always_comb begin
            w_st_nx  = r_st;
            w_sec_nx = r_sec;
            w_sub_nx = r_sub;
            w_exp_nx = 1'b0;
            if (clear[i]) begin
                w_st_nx  = c_ST_IDLE;
                w_sec_nx = '0;
                w_sub_nx = '0;
            end else if (load[i]) begin
                w_sec_nx = w_tar;
                w_sub_nx = '0;
                w_st_nx  = (w_tar != '0) ? c_ST_PAUSE : c_ST_IDLE;
            end else if (r_st == c_ST_ALARM) begin
                if (ack[i]) begin
                    w_st_nx = c_ST_IDLE;
                end
            end else if (r_st == c_ST_RUN) begin
                if (pause[i] && !run[i]) begin
                    w_st_nx = c_ST_PAUSE;
                end
                if (r_sub == c_SUB_LAST) begin
                    w_sub_nx = '0;
                    if (r_sec == W'(1)) begin
                        w_exp_nx = 1'b1;
`ifdef CDT_AUTORELOAD_EN
                        if (auto_rl[i]) begin
                            w_sec_nx = r_reload;
                        end else begin
                            w_sec_nx = '0;
                            w_st_nx  = c_ST_ALARM;
                        end
`else
                        w_sec_nx = '0;
                        w_st_nx  = c_ST_ALARM;
`endif
                    end else if (r_sec != '0) begin
                        w_sec_nx = r_sec - W'(1);
                    end
                end else begin
                    w_sub_nx = r_sub + SW'(1);
                end
            end else if (r_st == c_ST_PAUSE) begin
                if (run[i] && !pause[i]) begin
                    w_st_nx = c_ST_RUN;
                end
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_st  <= c_ST_IDLE;
                r_sec <= '0;
                r_sub <= '0;
                r_exp <= 1'b0;
            end else begin
                r_st  <= w_st_nx;
                r_sec <= w_sec_nx;
                r_sub <= w_sub_nx;
                r_exp <= w_exp_nx;
            end
        end

        assign seconds[i*W +: W] = r_sec;
        assign state[2*i +: 2]   = r_st;
        assign expired[i]        = r_exp;
        assign w_alarm[i]        = (r_st == c_ST_ALARM);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_buzzer <= 1'b0;
        end else begin
            r_buzzer <= |w_alarm;
        end
    end

    assign buzzer = r_buzzer;

endmodule
`default_nettype wire

// File: tb/tb_multi_countdown.sv
`default_nettype none
// Bench for multi_countdown (CH=2, W=17, TICK_DIV=4): directed stimulus feeding
// an expectation queue, checked by an independent monitor process.
module tb_multi_countdown;
    localparam int CH = 2;
    localparam int W  = 17;
    localparam int TD = 4;

    localparam logic [1:0] c_IDLE  = 2'b00;
    localparam logic [1:0] c_PAUSE = 2'b01;
    localparam logic [1:0] c_RUN   = 2'b10;
    localparam logic [1:0] c_ALARM = 2'b11;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [CH-1:0]   clear = '0;
    logic [CH-1:0]   load  = '0;
    logic [CH-1:0]   run   = '0;
    logic [CH-1:0]   pause = '0;
    logic [CH-1:0]   ack   = '0;
    logic [CH*W-1:0] tar_sec = '0;
    logic [CH*W-1:0] seconds;
    logic [2*CH-1:0] state;
    logic [CH-1:0]   expired;
    logic            buzzer;

    int cyc = 0;
    int checks = 0;
    int failures = 0;

    typedef struct {
        int         cyc;
        int         ch;
        logic [1:0] st;
        logic [W-1:0] sec;
        logic       buz;
        string      name;
    } obs_t;

    typedef struct {
        int cyc;
        int ch;
    } ev_t;

    obs_t obs_q[$];
    ev_t  ev_q[$];

    multi_countdown #(.CH(CH), .W(W), .TICK_DIV(TD)) dut (
        .clk     (clk),
        .rst     (rst),
        .clear   (clear),
        .load    (load),
        .tar_sec (tar_sec),
        .run     (run),
        .pause   (pause),
        .ack     (ack),
`ifdef CDT_AUTORELOAD_EN
        .auto_rl ('0),
`endif
        .seconds (seconds),
        .state   (state),
        .expired (expired),
        .buzzer  (buzzer)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic expect_at(input int at, input int ch, input logic [1:0] st,
                             input int sec, input logic buz, input string name);
        obs_t o;
        o.cyc  = at;
        o.ch   = ch;
        o.st   = st;
        o.sec  = sec[W-1:0];
        o.buz  = buz;
        o.name = name;
        obs_q.push_back(o);
    endtask

    task automatic expect_ev(input int at, input int ch);
        ev_t e;
        e.cyc = at;
        e.ch  = ch;
        ev_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_to(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic set_tar(input int ch, input int v);
        logic [W-1:0] t;
        t = v[W-1:0];
        tar_sec[ch*W +: W] = t;
    endtask

    // Monitor: compares queued expectations and expiry pulses each cycle.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            for (int i = obs_q.size() - 1; i >= 0; i--) begin
                if (obs_q[i].cyc <= cyc) begin
                    checks++;
                    if (state[2*obs_q[i].ch +: 2] !== obs_q[i].st ||
                        seconds[obs_q[i].ch*W +: W] !== obs_q[i].sec ||
                        buzzer !== obs_q[i].buz || obs_q[i].cyc != cyc) begin
                        failures++;
                        $display("FAIL %s ch%0d cyc=%0d: got state=%0d sec=%0d buz=%0b, want state=%0d sec=%0d buz=%0b (at cyc %0d)",
                                 obs_q[i].name, obs_q[i].ch, cyc, state[2*obs_q[i].ch +: 2],
                                 seconds[obs_q[i].ch*W +: W], buzzer, obs_q[i].st,
                                 obs_q[i].sec, obs_q[i].buz, obs_q[i].cyc);
                    end
                    obs_q.delete(i);
                end
            end
            for (int i = ev_q.size() - 1; i >= 0; i--) begin
                if (ev_q[i].cyc < cyc) begin
                    checks++;
                    failures++;
                    $display("FAIL expired_missing ch%0d: got no pulse, want pulse at cyc %0d",
                             ev_q[i].ch, ev_q[i].cyc);
                    ev_q.delete(i);
                end
            end
            for (int c = 0; c < CH; c++) begin
                if (expired[c] !== 1'b0) begin
                    int idx;
                    idx = -1;
                    for (int i = 0; i < ev_q.size(); i++) begin
                        if (idx < 0 && ev_q[i].ch == c && ev_q[i].cyc == cyc) idx = i;
                    end
                    checks++;
                    if (idx < 0) begin
                        failures++;
                        $display("FAIL expired_unexpected ch%0d: got expired=%b at cyc %0d, want 0",
                                 c, expired[c], cyc);
                    end else begin
                        ev_q.delete(idx);
                    end
                end
            end
        end
    end

    initial begin
        int r;
        int s;
        int a;

        tick(3);
        rst = 1'b0;
        expect_at(cyc, 0, c_IDLE, 0, 1'b0, "reset_ch0");
        expect_at(cyc, 1, c_IDLE, 0, 1'b0, "reset_ch1");
        tick(1);

        // Basic one-shot countdown from 3 on ch0, then ack.
        set_tar(0, 3);
        load = 2'b01;
        expect_at(cyc + 1, 0, c_PAUSE, 3, 1'b0, "t1_load");
        tick(1);
        load = 2'b00;
        run  = 2'b01;
        r = cyc + 1;
        expect_at(r,      0, c_RUN,   3, 1'b0, "t1_run");
        expect_at(r + 4,  0, c_RUN,   2, 1'b0, "t1_sec2");
        expect_at(r + 8,  0, c_RUN,   1, 1'b0, "t1_sec1");
        expect_at(r + 12, 0, c_ALARM, 0, 1'b0, "t1_alarm");
        expect_at(r + 13, 0, c_ALARM, 0, 1'b1, "t1_buzzer");
        expect_ev(r + 12, 0);
        tick(1);
        run = 2'b00;
        wait_to(r + 13);
        ack = 2'b01;
        expect_at(cyc + 1, 0, c_IDLE, 0, 1'b1, "t1_ack");
        expect_at(cyc + 2, 0, c_IDLE, 0, 1'b0, "t1_buzzer_off");
        tick(1);
        ack = 2'b00;
        tick(2);

        // Pause after two RUN cycles, hold, resume; sub-second position retained.
        set_tar(0, 5);
        load = 2'b01;
        expect_at(cyc + 1, 0, c_PAUSE, 5, 1'b0, "t2_load");
        tick(1);
        load = 2'b00;
        run  = 2'b01;
        expect_at(cyc + 1, 0, c_RUN, 5, 1'b0, "t2_run");
        tick(1);
        run = 2'b00;
        tick(1);
        pause = 2'b01;
        expect_at(cyc + 1, 0, c_PAUSE, 5, 1'b0, "t2_pause");
        tick(1);
        pause = 2'b00;
        expect_at(cyc + 6, 0, c_PAUSE, 5, 1'b0, "t2_hold");
        tick(6);
        run   = 2'b01;
        pause = 2'b01;
        expect_at(cyc + 1, 0, c_PAUSE, 5, 1'b0, "t2_run_with_pause");
        tick(1);
        pause = 2'b00;
        s = cyc + 1;
        expect_at(s,     0, c_RUN, 5, 1'b0, "t2_resume");
        expect_at(s + 1, 0, c_RUN, 5, 1'b0, "t2_resume_plus1");
        expect_at(s + 2, 0, c_RUN, 4, 1'b0, "t2_dec_after_resume");
        tick(1);
        run = 2'b00;
        wait_to(s + 2);
        clear = 2'b01;
        expect_at(cyc + 1, 0, c_IDLE, 0, 1'b0, "t2_clear");
        tick(1);
        clear = 2'b00;
        tick(1);

        // Load of zero stays IDLE and ignores run.
        set_tar(0, 0);
        load = 2'b01;
        expect_at(cyc + 1, 0, c_IDLE, 0, 1'b0, "t3_load0");
        tick(1);
        load = 2'b00;
        run  = 2'b01;
        expect_at(cyc + 1, 0, c_IDLE, 0, 1'b0, "t3_run_ignored");
        expect_at(cyc + 3, 0, c_IDLE, 0, 1'b0, "t3_still_idle");
        tick(1);
        run = 2'b00;
        tick(3);

        // Ack outside ALARM is ignored; clear beats load.
        set_tar(1, 7);
        load = 2'b10;
        expect_at(cyc + 1, 1, c_PAUSE, 7, 1'b0, "t4_load7");
        tick(1);
        load = 2'b00;
        ack  = 2'b10;
        expect_at(cyc + 1, 1, c_PAUSE, 7, 1'b0, "t4_ack_ignored");
        tick(1);
        ack = 2'b00;
        set_tar(1, 9);
        clear = 2'b10;
        load  = 2'b10;
        expect_at(cyc + 1, 1, c_IDLE, 0, 1'b0, "t4_clear_over_load");
        tick(1);
        clear = 2'b00;
        load  = 2'b00;
        tick(1);

        // Two channels running together with different targets.
        set_tar(0, 2);
        set_tar(1, 4);
        load = 2'b11;
        expect_at(cyc + 1, 0, c_PAUSE, 2, 1'b0, "t5_load_ch0");
        expect_at(cyc + 1, 1, c_PAUSE, 4, 1'b0, "t5_load_ch1");
        tick(1);
        load = 2'b00;
        run  = 2'b11;
        r = cyc + 1;
        expect_at(r + 4,  0, c_RUN,   1, 1'b0, "t5_ch0_sec1");
        expect_at(r + 5,  1, c_RUN,   3, 1'b0, "t5_ch1_ack_in_run");
        expect_at(r + 8,  0, c_ALARM, 0, 1'b0, "t5_ch0_alarm");
        expect_at(r + 8,  1, c_RUN,   2, 1'b0, "t5_ch1_sec2");
        expect_at(r + 9,  0, c_ALARM, 0, 1'b1, "t5_buzzer_on");
        expect_at(r + 16, 1, c_ALARM, 0, 1'b1, "t5_ch1_alarm");
        expect_ev(r + 8, 0);
        expect_ev(r + 16, 1);
        tick(1);
        run = 2'b00;
        wait_to(r + 4);
        ack = 2'b10;
        tick(1);
        ack = 2'b00;
        wait_to(r + 16);
        ack = 2'b01;
        a = cyc + 1;
        expect_at(a,     0, c_IDLE, 0, 1'b1, "t5_ack_ch0");
        expect_at(a + 1, 0, c_IDLE, 0, 1'b1, "t5_buzzer_held");
        tick(1);
        ack = 2'b00;
        tick(1);
        ack = 2'b10;
        a = cyc + 1;
        expect_at(a,     1, c_IDLE, 0, 1'b1, "t5_ack_ch1");
        expect_at(a + 1, 1, c_IDLE, 0, 1'b0, "t5_buzzer_off");
        tick(1);
        ack = 2'b00;
        tick(2);

        // Pause on the same edge as a second tick still decrements; ch1 left in ALARM.
        set_tar(1, 2);
        load = 2'b10;
        tick(1);
        load = 2'b00;
        run  = 2'b10;
        r = cyc + 1;
        tick(1);
        run = 2'b00;
        wait_to(r + 3);
        pause = 2'b10;
        expect_at(r + 4, 1, c_PAUSE, 1, 1'b0, "t6_pause_with_tick");
        tick(1);
        pause = 2'b00;
        tick(1);
        run = 2'b10;
        s = cyc + 1;
        expect_at(s + 3, 1, c_RUN,   1, 1'b0, "t6_resume_sec1");
        expect_at(s + 4, 1, c_ALARM, 0, 1'b0, "t6_alarm");
        expect_ev(s + 4, 1);
        tick(1);
        run = 2'b00;
        wait_to(s + 6);

        // Asynchronous reset mid-RUN with ch1 buzzing, then resume.
        set_tar(0, 3);
        load = 2'b01;
        tick(1);
        load = 2'b00;
        run  = 2'b01;
        tick(1);
        run = 2'b00;
        tick(5);
        expect_at(cyc, 0, c_RUN, 2, 1'b1, "t7_before_rst");
        tick(1);
        rst = 1'b1;
        expect_at(cyc, 0, c_IDLE, 0, 1'b0, "t7_rst_ch0");
        expect_at(cyc, 1, c_IDLE, 0, 1'b0, "t7_rst_ch1");
        tick(2);
        rst = 1'b0;
        set_tar(0, 1);
        load = 2'b01;
        expect_at(cyc + 1, 0, c_PAUSE, 1, 1'b0, "t7_load_after_rst");
        tick(1);
        load = 2'b00;
        run  = 2'b01;
        r = cyc + 1;
        expect_at(r + 4, 0, c_ALARM, 0, 1'b0, "t7_alarm");
        expect_ev(r + 4, 0);
        tick(1);
        run = 2'b00;
        wait_to(r + 5);
        ack = 2'b01;
        tick(1);
        ack = 2'b00;
        tick(3);

        foreach (obs_q[i]) begin
            checks++;
            failures++;
            $display("FAIL %s ch%0d: got no sample, want check at cyc %0d", obs_q[i].name, obs_q[i].ch, obs_q[i].cyc);
        end
        foreach (ev_q[i]) begin
            checks++;
            failures++;
            $display("FAIL expired_missing ch%0d: got no pulse, want pulse at cyc %0d", ev_q[i].ch, ev_q[i].cyc);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
